combi_decode_stage: RTL and testbench
=====================================

COMBI_DECODE_STAGE -- requirements
Module: combi_decode_stage

Interface
REQ-001 The block SHALL have parameter HYST_DEPTH, default 2, meaning the number of consecutive single-ISA decodes of the non-current ISA needed to switch the sticky mode (legal range 1..15).
REQ-002 The block SHALL have parameter INIT_ARM, default 0, meaning the mode after reset (1 = ARM, 0 = RISC-V).
REQ-003 The block SHALL have parameter ILL_CNT_W, default 8, meaning the width of the illegal-instruction counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: the asynchronous active-low reset.
REQ-007 The block SHALL have port instrF, input, 32 bits: the fetched instruction.
REQ-008 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the fetch-side handshake.
REQ-009 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the execute-side handshake.
REQ-010 The block SHALL have port flushD, input, 1 bit: the pipeline flush.
REQ-011 The block SHALL have port ctrlD, output, ctrl_t: the registered control bundle (RegWrite, MemWrite, ALUControl[3:0], Branch, ALUSrc, ImmSrc[2:0], PCSrc, FlagWrite[1:0], RegSrc[1:0], ResultSrc[1:0], PCRes, Jump).
REQ-012 The block SHALL have port armD, output, 1 bit: the ISA used to decode the held instruction.
REQ-013 The block SHALL have port illegalD, output, 1 bit: set when the held instruction is valid in neither ISA.
REQ-014 The block SHALL have port mode_arm, output, 1 bit: the current sticky mode.
REQ-015 The block SHALL have port ill_count, output, ILL_CNT_W bits: the saturating count of illegal instructions.

Function
REQ-016 The block SHALL decode each instruction through both ISA decoders at once, producing rv_ok (opcode legal and ALU function legal) and arm_ok (Op != 11 and, for data-processing, Funct[4:1] is one of ADD, SUB, AND or ORR).
REQ-017 The block SHALL select the decode ISA as follows: only arm_ok gives ARM; only rv_ok gives RISC-V; both give mode_arm; neither gives illegal.
REQ-018 The block SHALL hold the mode FSM in one of two states, MODE_RV or MODE_ARM, plus a switch counter sw_cnt that is 4 bits wide.
REQ-019 On each accepted, unflushed beat, sw_cnt SHALL increment when the instruction is single-ISA of the non-current ISA; at HYST_DEPTH the mode SHALL toggle and sw_cnt clear.
REQ-020 On each accepted, unflushed beat that is single-ISA of the current ISA, or illegal, sw_cnt SHALL clear; on an ambiguous beat sw_cnt SHALL hold.
REQ-021 A beat whose mode toggles SHALL still decode via REQ-017, and the new mode SHALL apply from the next beat.
REQ-022 An illegal beat SHALL set illegalD and force RegWrite, MemWrite, Branch, Jump, PCSrc and FlagWrite to 0, with all other control fields at 0.
REQ-023 An illegal beat SHALL leave the mode unchanged and SHALL increment ill_count, saturating at all-ones.
REQ-024 Fields that belong to the unused ISA SHALL be driven to 0, not X.
REQ-025 The block SHALL have one pipeline register with a latency of 1 cycle, and in_ready SHALL equal !out_valid || out_ready.
REQ-026 A beat SHALL be accepted when in_valid && in_ready, and ctrlD, armD and illegalD SHALL update only on an accepted beat.
REQ-027 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-028 flushD SHALL take priority: the next out_valid SHALL be 0, any beat accepted in the same cycle SHALL be dropped, and the mode, sw_cnt and ill_count SHALL not update.
REQ-029 in_ready SHALL be unaffected by flushD.

Reset
REQ-030 While reset_n is low, the block SHALL immediately force out_valid=0, ctrlD=0, illegalD=0, ill_count=0, sw_cnt=0, mode_arm=INIT_ARM and armD=INIT_ARM.
REQ-031 A reset mid-stream SHALL discard the held beat, and the first beat after release SHALL see the reset mode.

Structure
REQ-032 Package combi_pkg SHALL hold ctrl_t, the isa_e enum {ISA_RV, ISA_ARM}, the ALU control encodings and the RISC-V opcode constants.
REQ-033 The block SHALL have one combinational sub-module, combi_ctrl_lut, which maps instr to the RISC-V bundle, the ARM bundle, rv_ok and arm_ok.
REQ-034 The FSM, handshake and counters SHALL reside in combi_decode_stage.

Verification
REQ-035 Reset with INIT_ARM=0 -> mode_arm=0, out_valid=0, ill_count=0; release and send 0x00000013 -> one cycle later out_valid=1, armD=0, RegWrite=1, ALUSrc=1.
REQ-036 HYST_DEPTH=2: send 0xE2811001, then 0x00000013 -> second beat armD=0; send 0xE2811001 twice, then 0x00000013 -> mode_arm=1 and the third beat has armD=1 with the ARM AND decode.
REQ-037 Send 0xFFFFFFFF -> illegalD=1, RegWrite=0, MemWrite=0, ill_count=1, mode unchanged; 300 illegal beats -> ill_count=255.
REQ-038 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and ctrlD stable; raise out_ready -> next beat accepted the same cycle.
REQ-039 Mode ARM, flushD=1 with in_valid=1 and instrF=0xFFF00093 -> next out_valid=0, mode_arm=1, sw_cnt unchanged.
REQ-040 Assert reset_n=0 mid-stream with out_valid=1 -> out_valid drops with no clock edge, and mode returns to INIT_ARM.

Source files
------------

// File: rtl/combi_pkg.sv
// Shared types and encodings for the dual-ISA (RISC-V / ARM) decode stage.
package combi_pkg;

    typedef enum logic {ISA_RV = 1'b0, ISA_ARM = 1'b1} isa_e;
    typedef enum logic {MODE_RV = 1'b0, MODE_ARM = 1'b1} mode_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ARM data-processing cmd field (instr[24:21])
    localparam logic [3:0] ARM_AND = 4'b0000;
    localparam logic [3:0] ARM_SUB = 4'b0010;
    localparam logic [3:0] ARM_ADD = 4'b0100;
    localparam logic [3:0] ARM_ORR = 4'b1100;

    typedef struct packed {
        logic       RegWrite;
        logic       MemWrite;
        logic [3:0] ALUControl;
        logic       Branch;
        logic       ALUSrc;
        logic [2:0] ImmSrc;
        logic       PCSrc;
        logic [1:0] FlagWrite;
        logic [1:0] RegSrc;
        logic [1:0] ResultSrc;
        logic       PCRes;
        logic       Jump;
    } ctrl_t;

endpackage

// File: rtl/combi_ctrl_lut.sv
// Combinational dual decoder: builds both the RISC-V and ARM control bundles
// for one instruction along with each ISA's legality flag.
module combi_ctrl_lut
    import combi_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       rv_ctrl,
    output ctrl_t       arm_ctrl,
    output logic        rv_ok,
    output logic        arm_ok
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alu_ok;
    logic [3:0] alu_sel;
    logic [1:0] arm_op;
    logic [3:0] arm_cmd;
    logic       arm_s;
    logic       arm_rd_pc;

    assign opc       = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];
    assign arm_op    = instr[27:26];
    assign arm_cmd   = instr[24:21];
    assign arm_s     = instr[20];
    assign arm_rd_pc = (instr[15:12] == 4'hF);

    // funct3 decode is shared by R and I formats; only R checks funct7
    always_comb begin
        alu_ok  = 1'b1;
        alu_sel = ALU_ADD;
        case (f3)
            3'b000:  alu_sel = (opc == OP_R && f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_sel = ALU_SLT;
            3'b110:  alu_sel = ALU_OR;
            3'b111:  alu_sel = ALU_AND;
            default: alu_ok  = 1'b0;
        endcase
        if (opc == OP_R && !(f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b000)))
            alu_ok = 1'b0;
    end

    always_comb begin
        rv_ctrl = '0;
        rv_ok   = 1'b0;
        case (opc)
            OP_LOAD: begin
                rv_ok              = 1'b1;
                rv_ctrl.RegWrite   = 1'b1;
                rv_ctrl.ALUSrc     = 1'b1;
                rv_ctrl.ResultSrc  = 2'b01;
                rv_ctrl.ALUControl = ALU_ADD;
            end
            OP_STORE: begin
                rv_ok              = 1'b1;
                rv_ctrl.MemWrite   = 1'b1;
                rv_ctrl.ALUSrc     = 1'b1;
                rv_ctrl.ImmSrc     = 3'b001;
                rv_ctrl.ALUControl = ALU_ADD;
            end
            OP_R: begin
                rv_ok              = alu_ok;
                rv_ctrl.RegWrite   = 1'b1;
                rv_ctrl.ALUControl = alu_sel;
            end
            OP_IMM: begin
                rv_ok              = alu_ok;
                rv_ctrl.RegWrite   = 1'b1;
                rv_ctrl.ALUSrc     = 1'b1;
                rv_ctrl.ALUControl = alu_sel;
            end
            OP_BRANCH: begin
                rv_ok              = 1'b1;
                rv_ctrl.Branch     = 1'b1;
                rv_ctrl.ImmSrc     = 3'b010;
                rv_ctrl.ALUControl = ALU_SUB;
            end
            OP_JAL: begin
                rv_ok              = 1'b1;
                rv_ctrl.RegWrite   = 1'b1;
                rv_ctrl.ImmSrc     = 3'b011;
                rv_ctrl.ResultSrc  = 2'b10;
                rv_ctrl.Jump       = 1'b1;
                rv_ctrl.PCRes      = 1'b1;
                rv_ctrl.ALUControl = ALU_ADD;
            end
            default: ;
        endcase
    end

    always_comb begin
        arm_ctrl = '0;
        arm_ok   = 1'b0;
        case (arm_op)
            2'b00: begin
                arm_ok = 1'b1;
                case (arm_cmd)
                    ARM_ADD: arm_ctrl.ALUControl = ALU_ADD;
                    ARM_SUB: arm_ctrl.ALUControl = ALU_SUB;
                    ARM_AND: arm_ctrl.ALUControl = ALU_AND;
                    ARM_ORR: arm_ctrl.ALUControl = ALU_OR;
                    default: arm_ok = 1'b0;
                endcase
                arm_ctrl.RegWrite  = 1'b1;
                arm_ctrl.ALUSrc    = instr[25];
                // C/V flags only make sense for arithmetic ops
                arm_ctrl.FlagWrite = {arm_s, arm_s & (arm_cmd == ARM_ADD || arm_cmd == ARM_SUB)};
                arm_ctrl.PCSrc     = arm_rd_pc;
            end
            2'b01: begin
                arm_ok              = 1'b1;
                arm_ctrl.ALUSrc     = 1'b1;
                arm_ctrl.ImmSrc     = 3'b001;
                arm_ctrl.ALUControl = ALU_ADD;
                if (instr[20]) begin
                    arm_ctrl.RegWrite  = 1'b1;
                    arm_ctrl.ResultSrc = 2'b01;
                    arm_ctrl.PCSrc     = arm_rd_pc;
                end else begin
                    arm_ctrl.MemWrite  = 1'b1;
                    arm_ctrl.RegSrc    = 2'b10;
                end
            end
            2'b10: begin
                arm_ok              = 1'b1;
                arm_ctrl.Branch     = 1'b1;
                arm_ctrl.ALUSrc     = 1'b1;
                arm_ctrl.ImmSrc     = 3'b010;
                arm_ctrl.RegSrc     = 2'b01;
                arm_ctrl.ALUControl = ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/combi_decode_stage.sv
// Dual-ISA decode stage: one-deep skid-free pipeline register, sticky ISA mode
// with switch hysteresis, and a saturating illegal-instruction counter.
module combi_decode_stage
    import combi_pkg::*;
#(
    parameter int HYST_DEPTH = 2,
    parameter bit INIT_ARM   = 1'b0,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          instrF,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flushD,
    output ctrl_t                ctrlD,
    output logic                 armD,
    output logic                 illegalD,
    output logic                 mode_arm,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam mode_e      MODE_INIT = INIT_ARM ? MODE_ARM : MODE_RV;
    localparam logic [3:0] SW_LAST   = 4'(HYST_DEPTH - 1);

    ctrl_t rv_ctrl, arm_ctrl, dec_ctrl;
    logic  rv_ok, arm_ok;
    logic  single_rv, single_arm, ill;
    logic  foreign, native;
    logic  fire;
    isa_e  dec_isa;
    mode_e state_q, state_d;
    logic [3:0] sw_cnt, sw_cnt_d;

    combi_ctrl_lut u_lut (
        .instr    (instrF),
        .rv_ctrl  (rv_ctrl),
        .arm_ctrl (arm_ctrl),
        .rv_ok    (rv_ok),
        .arm_ok   (arm_ok)
    );

    assign in_ready   = !out_valid || out_ready;
    assign fire       = in_valid && in_ready && !flushD;
    assign single_rv  = rv_ok && !arm_ok;
    assign single_arm = arm_ok && !rv_ok;
    assign ill        = !rv_ok && !arm_ok;
    assign foreign    = (state_q == MODE_RV) ? single_arm : single_rv;
    assign native     = (state_q == MODE_RV) ? single_rv  : single_arm;

    // Ambiguous encodings follow the sticky mode as it stands before this beat
    always_comb begin
        if (single_arm)     dec_isa = ISA_ARM;
        else if (single_rv) dec_isa = ISA_RV;
        else                dec_isa = mode_arm ? ISA_ARM : ISA_RV;
        if (ill)                     dec_ctrl = '0;
        else if (dec_isa == ISA_ARM) dec_ctrl = arm_ctrl;
        else                         dec_ctrl = rv_ctrl;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MODE_INIT;
            sw_cnt  <= '0;
        end else begin
            state_q <= state_d;
            sw_cnt  <= sw_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sw_cnt_d = sw_cnt;
        if (fire) begin
            if (foreign) begin
                if (sw_cnt >= SW_LAST) begin
                    state_d  = (state_q == MODE_RV) ? MODE_ARM : MODE_RV;
                    sw_cnt_d = '0;
                end else begin
                    sw_cnt_d = sw_cnt + 4'd1;
                end
            end else if (native || ill) begin
                sw_cnt_d = '0;
            end
        end
    end

    always_comb begin
        mode_arm = (state_q == MODE_ARM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            ctrlD     <= '0;
            armD      <= INIT_ARM;
            illegalD  <= 1'b0;
            ill_count <= '0;
        end else begin
            if (flushD)        out_valid <= 1'b0;
            else if (in_ready) out_valid <= in_valid;
            if (fire) begin
                ctrlD    <= dec_ctrl;
                armD     <= (dec_isa == ISA_ARM) && !ill;
                illegalD <= ill;
                if (ill && ill_count != '1)
                    ill_count <= ill_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_combi_decode_stage.sv
// Randomized + directed bench for combi_decode_stage against a behavioural model.
module tb_combi_decode_stage;
    import combi_pkg::*;

    localparam int HYST = 2;
    localparam bit INIT = 1'b0;
    localparam int ICW  = 8;
    localparam int ICMAX = (1 << ICW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] instrF = '0;
    logic in_valid = 1'b0, out_ready = 1'b1, flushD = 1'b0;
    logic in_ready, out_valid, armD, illegalD, mode_arm;
    ctrl_t ctrlD;
    logic [ICW-1:0] ill_count;

    always #5 clk = ~clk;

    combi_decode_stage #(.HYST_DEPTH(HYST), .INIT_ARM(INIT), .ILL_CNT_W(ICW)) dut (
        .clk(clk), .reset_n(reset_n), .instrF(instrF), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .flushD(flushD), .ctrlD(ctrlD), .armD(armD), .illegalD(illegalD),
        .mode_arm(mode_arm), .ill_count(ill_count)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state: what the stage should be holding after each edge
    bit    m_valid, m_arm, m_ill, m_mode;
    ctrl_t m_ctrl;
    int    m_run, m_ill_cnt;

    function automatic void ref_dec(input logic [31:0] i, output bit rv_ok, output bit arm_ok,
                                    output ctrl_t rv, output ctrl_t am);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] cmd;
        bit alu_good;
        logic [3:0] alu;
        opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; cmd = i[24:21];
        rv = '0; am = '0; rv_ok = 0; arm_ok = 0;
        alu_good = 1; alu = ALU_ADD;
        if (opc == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0)      alu = ALU_ADD;
            else if (f7 == 7'h20 && f3 == 3'd0) alu = ALU_SUB;
            else if (f7 == 7'h00 && f3 == 3'd2) alu = ALU_SLT;
            else if (f7 == 7'h00 && f3 == 3'd6) alu = ALU_OR;
            else if (f7 == 7'h00 && f3 == 3'd7) alu = ALU_AND;
            else alu_good = 0;
        end else begin
            if (f3 == 3'd0)      alu = ALU_ADD;
            else if (f3 == 3'd2) alu = ALU_SLT;
            else if (f3 == 3'd6) alu = ALU_OR;
            else if (f3 == 3'd7) alu = ALU_AND;
            else alu_good = 0;
        end
        if (opc == 7'h03) begin rv_ok = 1; rv.RegWrite = 1; rv.ALUSrc = 1; rv.ResultSrc = 1; end
        else if (opc == 7'h23) begin rv_ok = 1; rv.MemWrite = 1; rv.ALUSrc = 1; rv.ImmSrc = 1; end
        else if (opc == 7'h33) begin rv_ok = alu_good; rv.RegWrite = 1; rv.ALUControl = alu; end
        else if (opc == 7'h13) begin rv_ok = alu_good; rv.RegWrite = 1; rv.ALUSrc = 1; rv.ALUControl = alu; end
        else if (opc == 7'h63) begin rv_ok = 1; rv.Branch = 1; rv.ImmSrc = 2; rv.ALUControl = ALU_SUB; end
        else if (opc == 7'h6F) begin
            rv_ok = 1; rv.RegWrite = 1; rv.ImmSrc = 3; rv.ResultSrc = 2; rv.Jump = 1; rv.PCRes = 1;
        end
        if (i[27:26] == 2'b00) begin
            arm_ok = (cmd == 4'd0 || cmd == 4'd2 || cmd == 4'd4 || cmd == 4'd12);
            am.ALUControl = (cmd == 4'd2) ? ALU_SUB : (cmd == 4'd0) ? ALU_AND : (cmd == 4'd12) ? ALU_OR : ALU_ADD;
            am.RegWrite = 1; am.ALUSrc = i[25];
            am.FlagWrite = {i[20], i[20] && (cmd == 4'd2 || cmd == 4'd4)};
            am.PCSrc = (i[15:12] == 4'hF);
        end else if (i[27:26] == 2'b01) begin
            arm_ok = 1; am.ALUSrc = 1; am.ImmSrc = 1;
            if (i[20]) begin am.RegWrite = 1; am.ResultSrc = 1; am.PCSrc = (i[15:12] == 4'hF); end
            else begin am.MemWrite = 1; am.RegSrc = 2'b10; end
        end else if (i[27:26] == 2'b10) begin
            arm_ok = 1; am.Branch = 1; am.ALUSrc = 1; am.ImmSrc = 2; am.RegSrc = 2'b01;
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; m_arm = INIT; m_ill = 0; m_mode = INIT; m_run = 0; m_ill_cnt = 0;
    endtask

    task automatic model_tick();
        bit rdy, rv_ok, arm_ok, use_arm;
        ctrl_t rvc, amc;
        rdy = !m_valid || out_ready;
        if (flushD) begin m_valid = 0; return; end
        if (in_valid && rdy) begin
            ref_dec(instrF, rv_ok, arm_ok, rvc, amc);
            if (!rv_ok && !arm_ok) begin
                m_ctrl = '0; m_arm = 0; m_ill = 1; m_run = 0;
                if (m_ill_cnt < ICMAX) m_ill_cnt++;
            end else begin
                use_arm = (rv_ok && arm_ok) ? m_mode : arm_ok;
                m_ctrl = use_arm ? amc : rvc; m_arm = use_arm; m_ill = 0;
                if (rv_ok != arm_ok) begin
                    if (arm_ok != m_mode) begin
                        m_run++;
                        if (m_run == HYST) begin m_mode = !m_mode; m_run = 0; end
                    end else m_run = 0;
                end
            end
            m_valid = 1;
        end else if (rdy) m_valid = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        chk("ctrlD", 32'(ctrlD), 32'(m_ctrl));
        chk("armD", 32'(armD), 32'(m_arm));
        chk("illegalD", 32'(illegalD), 32'(m_ill));
        chk("mode_arm", 32'(mode_arm), 32'(m_mode));
        chk("ill_count", 32'(ill_count), 32'(m_ill_cnt));
        chk("sw_cnt", 32'(dut.sw_cnt), 32'(m_run));
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [31:0] ins);
        in_valid = 1; instrF = ins; step();
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [3:0] cmds [4];
        logic [6:0] ops [6];
        logic [2:0] f3s [5];
        int k;
        cmds = '{4'd0, 4'd2, 4'd4, 4'd12};
        ops  = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
        f3s  = '{3'd0, 3'd2, 3'd6, 3'd7, 3'd5};
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 2) begin
            r[31:28] = 4'hE;
            r[27:26] = 2'($urandom_range(0, 2));
            if (r[27:26] == 2'b00 && $urandom_range(0, 3) != 0) r[24:21] = cmds[$urandom_range(0, 3)];
        end else if (k <= 5) begin
            r[6:0] = ops[$urandom_range(0, 5)];
            r[14:12] = f3s[$urandom_range(0, 4)];
            if (r[6:0] == 7'h33) r[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
            // keep most RV picks out of the ARM space so the mode actually moves
            if ($urandom_range(0, 3) != 0) r[27:26] = 2'b11;
        end else if (k == 6) r = 32'h0000_0013;
        else if (k == 7) r = 32'hFFFF_FFFF;
        return r;
    endfunction

    initial begin
        model_reset();
        do_reset();
        chk("rst_mode", 32'(mode_arm), 32'(INIT));
        chk("rst_valid", 32'(out_valid), 32'd0);

        // basic RISC-V addi
        send(32'h0000_0013);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_arm", 32'(armD), 32'd0);
        chk("addi_rw", 32'(ctrlD.RegWrite), 32'd1);
        chk("addi_alusrc", 32'(ctrlD.ALUSrc), 32'd1);

        // hysteresis: one ARM beat is not enough
        send(32'hE281_1001);
        send(32'h0000_0013);
        chk("hyst1_arm", 32'(armD), 32'd0);
        send(32'hFFF0_0093);
        send(32'hE281_1001);
        chk("hyst2_mode_hold", 32'(mode_arm), 32'd0);
        send(32'hE281_1001);
        chk("hyst2_mode_sw", 32'(mode_arm), 32'd1);
        send(32'h0000_0013);
        chk("hyst2_arm", 32'(armD), 32'd1);
        chk("hyst2_and", 32'(ctrlD.ALUControl), 32'(ALU_AND));
        chk("hyst2_alusrc", 32'(ctrlD.ALUSrc), 32'd0);

        // illegal handling and saturation
        send(32'hFFFF_FFFF);
        chk("ill_flag", 32'(illegalD), 32'd1);
        chk("ill_rw", 32'(ctrlD.RegWrite), 32'd0);
        chk("ill_mw", 32'(ctrlD.MemWrite), 32'd0);
        chk("ill_cnt1", 32'(ill_count), 32'd1);
        chk("ill_mode", 32'(mode_arm), 32'd1);
        for (int n = 0; n < 300; n++) send(32'hFFFF_FFFF);
        chk("ill_sat", 32'(ill_count), 32'd255);

        // backpressure
        in_valid = 1; instrF = 32'h0000_0013; out_ready = 0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("stall_rdy", 32'(in_ready), 32'd0);
            chk("stall_hold", 32'(illegalD), 32'd1);
        end
        out_ready = 1;
        #1;
        chk("unstall_rdy", 32'(in_ready), 32'd1);
        step();
        chk("unstall_ill", 32'(illegalD), 32'd0);
        chk("unstall_arm", 32'(armD), 32'd1);

        // flush drops the beat and freezes the mode machinery
        send(32'hFFF0_0093);
        chk("pre_flush_cnt", 32'(dut.sw_cnt), 32'd1);
        flushD = 1; instrF = 32'hFFF0_0093; in_valid = 1;
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_mode", 32'(mode_arm), 32'd1);
        chk("flush_cnt", 32'(dut.sw_cnt), 32'd1);
        flushD = 0;

        // asynchronous reset mid-stream
        send(32'h0000_0013);
        in_valid = 0;
        #3;
        reset_n = 0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_mode", 32'(mode_arm), 32'(INIT));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        send(32'h0000_0013);
        chk("post_rst_arm", 32'(armD), 32'(INIT));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flushD    = ($urandom_range(0, 15) == 0);
            instrF    = gen_instr();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
